jedro_1_dmem_responder: RTL and testbench
=========================================

JEDRO_1_DMEM_RESPONDER -- requirements
Module: jedro_1_dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words in the data RAM.
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra cycles (0..15) inserted between grant and response.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_i  input  1  LSU request valid; held until granted.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port be_i  input  4  byte enables, bit k = byte lane k (bits 8k+7:8k).
REQ-009 SHALL have port wdata_i  input  32  store data, already lane-aligned by the LSU.
REQ-010 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-011 SHALL have port rvalid_o  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata_o  output  32  full load word, valid while rvalid_o = 1.
REQ-013 SHALL have port err_o  output  1  access error, valid while rvalid_o = 1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 gnt_o SHALL equal req_i AND (state == IDLE), combinationally; never asserted in WAIT or RESP.
REQ-016 On handshake (req_i & gnt_o), SHALL register we_i, addr_i, be_i, wdata_i; later input changes SHALL have no effect on that transaction.
REQ-017 Handshake edge: IDLE -> WAIT with wait counter = WAIT_STATES-1 if WAIT_STATES > 0; otherwise IDLE -> RESP.
REQ-018 In WAIT, counter SHALL decrement each cycle; at counter == 0, WAIT -> RESP.
REQ-019 RESP SHALL last exactly one cycle with rvalid_o = 1, then return to IDLE; rvalid_o = 0 in all other states.
REQ-020 Latency: handshake in cycle N -> rvalid_o high in cycle N+1+WAIT_STATES; peak throughput one transaction per 2+WAIT_STATES cycles.
REQ-021 Word index = addr[31:2] of the latched address; access is out-of-range if index >= MEM_WORDS.
REQ-022 Legal be/offset pairs (addr[1:0]): byte 0001/00, 0010/01, 0100/10, 1000/11; half 0011/00, 1100/10; word 1111/00; any other pair, including be = 0000, is misaligned.
REQ-023 Out-of-range or misaligned access SHALL give err_o = 1 and rdata_o = 0 in RESP, and SHALL NOT modify memory.
REQ-024 A legal store SHALL write only enabled byte lanes, committed on the clock edge entering RESP; rdata_o = 0 and err_o = 0 in its RESP cycle.
REQ-025 A legal load SHALL return the full stored word on rdata_o with err_o = 0; the LSU performs lane extraction and sign extension.
REQ-026 A load of a word in the same cycle another store commits is impossible (single outstanding transaction); read-after-write across transactions SHALL return the new data.
REQ-027 Memory array SHALL NOT be reset; contents are undefined until written.

Reset
REQ-028 While rst_i = 1: state IDLE, wait counter 0, gnt_o = 0, rvalid_o = 0, rdata_o = 0, err_o = 0, latched request cleared.
REQ-029 Reset asserted before the commit edge of a pending store SHALL abort the store (memory unchanged); no response is produced for an aborted transaction.
REQ-030 After reset deassertion, the first rising edge with req_i = 1 SHALL be a legal handshake.

Verification
REQ-031 WAIT_STATES=0: store addr 0x10, be 1111, data 0xDEADBEEF; then load 0x10 -> gnt same cycle, rvalid one cycle later, rdata 0xDEADBEEF, err 0.
REQ-032 Byte store 0x55 at addr 0x13 (be 1000, wdata 0x55000000) over word 0xDEADBEEF; load 0x10 -> 0x55ADBEEF.
REQ-033 WAIT_STATES=3: load accepted cycle 10 -> rvalid exactly in cycle 14, gnt_o low cycles 11-14 despite req_i held high.
REQ-034 Misaligned store addr 0x11, be 0011 -> err 1, rdata 0; subsequent load 0x10 shows memory unchanged.
REQ-035 MEM_WORDS=1024: load addr 0x1000 -> err 1, rdata 0; load addr 0xFFC -> err 0.
REQ-036 WAIT_STATES=2: store accepted, rst_i pulsed in first WAIT cycle -> no rvalid, memory word unchanged, next request granted after reset release.

Source files
------------

// File: rtl/jedro_1_dmem_responder.sv
// Single-port data RAM responder for the jedro_1 LSU: one outstanding request,
// fixed wait states, whole-word load data and an error flag for bad accesses.
module jedro_1_dmem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [MEM_WORDS];

  logic          hs;
  logic          t_we;
  logic [31:0]   t_addr;
  logic [3:0]    t_be;
  logic [31:0]   t_wdata;
  logic          t_aligned;
  logic          t_oor;
  logic          t_err;
  logic [AW-1:0] t_idx;
  logic          commit;

  assign gnt_o = req_i && (state_q == StIdle) && !rst_i;
  assign hs    = gnt_o;

  // With zero wait states the store commits on the handshake edge itself,
  // before the request is latched, so the live inputs describe it in IDLE.
  always_comb begin
    if (state_q == StIdle) begin
      t_we    = we_i;
      t_addr  = addr_i;
      t_be    = be_i;
      t_wdata = wdata_i;
    end else begin
      t_we    = we_q;
      t_addr  = addr_q;
      t_be    = be_q;
      t_wdata = wdata_q;
    end
  end

  always_comb begin
    t_aligned = 1'b0;
    unique case ({t_be, t_addr[1:0]})
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
      6'b0011_00, 6'b1100_10, 6'b1111_00: t_aligned = 1'b1;
      default:                            t_aligned = 1'b0;
    endcase
  end

  assign t_oor = {2'b00, t_addr[31:2]} >= 32'(MEM_WORDS);
  assign t_err = t_oor || !t_aligned;
  assign t_idx = t_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Memory is never reset; a reset high at the commit edge aborts the store.
  assign commit = (state_d == StResp) && t_we && !t_err && !rst_i;

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (t_be[k]) begin
          mem[t_idx][8*k +: 8] <= t_wdata[8*k +: 8];
        end
      end
    end
  end

  assign rvalid_o = (state_q == StResp);
  assign err_o    = rvalid_o && t_err;
  assign rdata_o  = (rvalid_o && !we_q && !t_err) ? mem[t_idx] : 32'd0;

endmodule

// File: tb/tb_jedro_1_dmem_responder.sv
// Randomized self-checking bench: three responders (0, 2 and 3 wait states)
// checked against a word-array memory model and the access legality rules.
module tb_jedro_1_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  req, we;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  be [3];
  wire  [2:0]  gnt, rvalid, err;
  wire  [31:0] rdata [3];

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [3][1024];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jedro_1_dmem_responder #(
      .MEM_WORDS  (1024),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req[g]),
      .we_i    (we[g]),
      .addr_i  (addr[g]),
      .be_i    (be[g]),
      .wdata_i (wdata[g]),
      .gnt_o   (gnt[g]),
      .rvalid_o(rvalid[g]),
      .rdata_o (rdata[g]),
      .err_o   (err[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // Legal: byte/half/word size, naturally aligned, lanes matching the offset.
  function automatic logic legal(input logic [3:0] b, input logic [1:0] off);
    int n;
    logic [3:0] m;
    n = $countones(b);
    if (n == 1) m = 4'b0001;
    else if (n == 2) m = 4'b0011;
    else if (n == 4) m = 4'b1111;
    else return 1'b0;
    if ((int'(off) % n) != 0) return 1'b0;
    return b == 4'(m << off);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    #1;
    check("gnt", {31'd0, gnt[d]}, 32'd1);
    @(posedge clk);
    #1;
    // Request stays high and fields change: neither may affect the transaction.
    we[d] = ~w; addr[d] = $urandom; be[d] = 4'($urandom); wdata[d] = $urandom;
  endtask

  task automatic finish(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int ws;
    int idx;
    logic e_err;
    logic [31:0] e_rd;
    ws    = ws_of(d);
    idx   = int'(a >> 2);
    e_err = (idx >= 1024) || !legal(b, a[1:0]);
    e_rd  = (!w && !e_err) ? mdl[d][idx] : 32'd0;
    if (w && !e_err) begin
      for (int k = 0; k < 4; k++) if (b[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
    end
    rd = 32'd0;
    er = 1'b0;
    for (int c = 1; c <= ws + 1; c++) begin
      @(negedge clk);
      check("gnt_busy", {31'd0, gnt[d]}, 32'd0);
      check("rvalid", {31'd0, rvalid[d]}, {31'd0, c == ws + 1});
      if (c == ws + 1) begin
        rd = rdata[d];
        er = err[d];
        check("rdata", rdata[d], e_rd);
        check("err", {31'd0, err[d]}, {31'd0, e_err});
      end
    end
    req[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    start(d, w, a, b, wd);
    finish(d, w, a, b, wd, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [3:0] legal_be [7];
    logic [1:0] legal_off [7];
    legal_be  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    legal_off = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};

    req = '0; we = '0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = 3'b111;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_gnt", {31'd0, gnt[d]}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid[d]}, 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_err", {31'd0, err[d]}, 32'd0);
    end
    req = 3'b000;
    rst = 1'b0;

    // Give every word the bench will read a known value.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 17; i++) begin
        int w_i;
        w_i = (i == 16) ? 1023 : i;
        txn(d, 1'b1, 32'(w_i * 4), 4'b1111, $urandom, rd, er);
      end
    end

    txn(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er);
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check("word_load", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h13, 4'b1000, 32'h55000000, rd, er);
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check("byte_merge", rd, 32'h55ADBEEF);
    txn(0, 1'b1, 32'h11, 4'b0011, 32'h12345678, rd, er);
    check("misal_err", {31'd0, er}, 32'd1);
    check("misal_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check("misal_nowrite", rd, 32'h55ADBEEF);
    txn(0, 1'b0, 32'h1000, 4'b1111, 32'h0, rd, er);
    check("oor_err", {31'd0, er}, 32'd1);
    txn(0, 1'b0, 32'hFFC, 4'b1111, 32'h0, rd, er);
    check("last_word_err", {31'd0, er}, 32'd0);

    // Store aborted by reset during its first wait cycle.
    start(1, 1'b1, 32'h14, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_gnt", {31'd0, gnt[1]}, 32'd0);
    check("abort_rvalid", {31'd0, rvalid[1]}, 32'd0);
    check("abort_rdata", rdata[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_norsp", {31'd0, rvalid[1]}, 32'd0);
    end
    txn(1, 1'b0, 32'h14, 4'b1111, 32'h0, rd, er);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 60; n++) begin
        logic w;
        logic [31:0] a;
        logic [3:0] b;
        int sel;
        w = 1'($urandom);
        sel = int'($urandom_range(0, 9));
        a = {26'd0, 4'($urandom), 2'd0};
        if (sel == 8) a = 32'hFFC;
        if (sel == 9) a = 32'h1000 + {20'd0, 10'($urandom), 2'd0};
        if ($urandom_range(0, 3) != 0) begin
          int li;
          li = int'($urandom_range(0, 6));
          b = legal_be[li];
          a[1:0] = legal_off[li];
        end else begin
          b = 4'($urandom);
          a[1:0] = 2'($urandom);
        end
        txn(d, w, a, b, $urandom, rd, er);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
